rot_word: RTL and testbench

ROT_WORD -- requirements
Module: rot_word

---
 rtl/rot_word_pkg.sv | 44 ++++
 rtl/aes_sbox.sv | 12 +
 rtl/rot_word.sv | 49 ++++
 tb/tb_rot_word.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rot_word_pkg.sv
// Shared constants for rot_word: byte width, default sizing, AES S-box.
// The S-box table is only referenced when ROT_WORD_SUBWORD_EN is defined.
package rot_word_pkg;

  localparam int BYTE_W        = 8;
  localparam int WORD_DEF      = 32;
  localparam int ROT_BYTES_DEF = 1;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Instantiated by rot_word only when ROT_WORD_SUBWORD_EN is defined.
module aes_sbox
  import rot_word_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/rot_word.sv
// Registered byte-wise left rotation of a word (AES RotWord).
// Define ROT_WORD_SUBWORD_EN to add the AES S-box per byte.
module rot_word
  import rot_word_pkg::*;
#(
  parameter int WORD      = WORD_DEF,
  parameter int ROT_BYTES = ROT_BYTES_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [WORD-1:0] word_to_rotate,
  input  logic            in_valid,
  output logic [WORD-1:0] rotated_word,
  output logic            out_valid
);

  localparam int NB = WORD / BYTE_W;

  logic [WORD-1:0] rot;
  logic [WORD-1:0] nxt;

  // Output byte i takes input byte i-ROT_BYTES, modulo the byte count.
  for (genvar i = 0; i < NB; i++) begin : g_byte
    localparam int SRC = (i + NB - ROT_BYTES) % NB;
    assign rot[i*BYTE_W +: BYTE_W] =
      word_to_rotate[SRC*BYTE_W +: BYTE_W];
`ifdef ROT_WORD_SUBWORD_EN
    aes_sbox u_sbox (
      .din  (rot[i*BYTE_W +: BYTE_W]),
      .dout (nxt[i*BYTE_W +: BYTE_W])
    );
`else
    assign nxt[i*BYTE_W +: BYTE_W] =
      rot[i*BYTE_W +: BYTE_W];
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rotated_word <= '0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        rotated_word <= nxt;
    end
  end

endmodule

// File: tb/tb_rot_word.sv
// Scoreboard bench for rot_word (WORD=32) with ROT_BYTES 1, 0 and 3.
// Expectations switch to SubWord values when ROT_WORD_SUBWORD_EN is set.
module tb_rot_word;

  logic        Clk;
  logic        Rst;
  logic [31:0] word_to_rotate;
  logic        in_valid;
  logic [31:0] rotated_word;
  logic        out_valid;
  logic [31:0] r0_word;
  logic        r0_valid;
  logic [31:0] r3_word;
  logic        r3_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] held;

  rot_word #(.WORD(32), .ROT_BYTES(1)) dut (
    .Clk(Clk), .Rst(Rst),
    .word_to_rotate(word_to_rotate),
    .in_valid(in_valid),
    .rotated_word(rotated_word),
    .out_valid(out_valid)
  );

  rot_word #(.WORD(32), .ROT_BYTES(0)) dut_r0 (
    .Clk(Clk), .Rst(Rst),
    .word_to_rotate(word_to_rotate),
    .in_valid(in_valid),
    .rotated_word(r0_word),
    .out_valid(r0_valid)
  );

  rot_word #(.WORD(32), .ROT_BYTES(3)) dut_r3 (
    .Clk(Clk), .Rst(Rst),
    .word_to_rotate(word_to_rotate),
    .in_valid(in_valid),
    .rotated_word(r3_word),
    .out_valid(r3_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] pick(
    input logic [31:0] plain,
    input logic [31:0] sub
  );
`ifdef ROT_WORD_SUBWORD_EN
    return sub;
`else
    return plain;
`endif
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h",
               name, act, exp);
    end
  endtask

  // Drive at posedge+2, return at posedge+2 after the capturing edge.
  task automatic step(
    input logic [31:0] w,
    input logic        v,
    input logic [31:0] exp
  );
    word_to_rotate = w;
    in_valid       = v;
    if (v && !Rst)
      sb_q.push_back(exp);
    @(posedge Clk);
    #2;
  endtask

  always @(negedge Clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got %08h want none",
                 rotated_word);
      end else begin
        chk("scoreboard", rotated_word, sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst            = 1'b1;
    in_valid       = 1'b0;
    word_to_rotate = 32'h0;
    @(posedge Clk);
    #2;
    chk("reset_word", rotated_word, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    Rst = 1'b0;

    step(32'h0000FFFF, 1'b1, pick(32'h00FFFF00, 32'h63161663));
    step(32'h00009999, 1'b1, pick(32'h00999900, 32'h63eeee63));
    step(32'h0001C444, 1'b1, pick(32'h01C44400, 32'h7c1c1b63));
    step(32'h0000ABCD, 1'b1, pick(32'h00ABCD00, 32'h6362bd63));
    step(32'h00012341, 1'b1, pick(32'h01234100, 32'h7c268363));
    step(32'h00000000, 1'b1, pick(32'h00000000, 32'h63636363));

    step(32'hCAFEF00D, 1'b1, pick(32'hFEF00DCA, 32'hbb8cd774));
    chk("rot0", r0_word, pick(32'hCAFEF00D, 32'h74bb8cd7));
    step(32'h11223344, 1'b1, pick(32'h22334411, 32'h93c31b82));
    chk("rot3", r3_word, pick(32'h44112233, 32'h1b8293c3));

    held = pick(32'h34567812, 32'h18b1bcc9);
    step(32'h12345678, 1'b1, held);
    chk("hold_first", rotated_word, held);
    for (int i = 0; i < 3; i++) begin
      step(32'hDEADBEEF, 1'b0, 32'h0);
      chk("hold_word", rotated_word, held);
      chk("hold_valid", {31'b0, out_valid}, 32'h0);
    end

    step(32'h0000FFFF, 1'b1, pick(32'h00FFFF00, 32'h63161663));
    step(32'h00009999, 1'b1, pick(32'h00999900, 32'h63eeee63));
    Rst = 1'b1;
    sb_q.delete();
    #1;
    chk("async_rst_word", rotated_word, 32'h0);
    chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
    step(32'hDEADBEEF, 1'b1, 32'h0);
    chk("rst_ignore_word", rotated_word, 32'h0);
    chk("rst_ignore_valid", {31'b0, out_valid}, 32'h0);
    Rst = 1'b0;

    step(32'h00012341, 1'b1, pick(32'h01234100, 32'h7c268363));
    chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
    step(32'h0, 1'b0, 32'h0);
    step(32'h0, 1'b0, 32'h0);

    chk("sb_drained", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
